cpu_stage_sequencer: RTL and testbench

Multi-cycle stage controller for the MIPS-32 core. It steps one instruction at a time through FETCH, DECODE, EXECUTE, optional MEMORY, and WRITEBACK. It generates the per-stage enables, register-file and data-memory write strobes, and the PC update select that the registered memories, register file and ALU need. It also arbitrates memory ownership between the external program loader and the running core.

---
 rtl/cpu_stage_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_cpu_stage_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_stage_sequencer.sv
// cpu_stage_sequencer
// Multi-cycle stage controller: steps one instruction at a time through
// FETCH, DECODE, EXEC, optional MEM and WB. It drives the per-stage strobes,
// the register-file and data-memory write strobes and the PC source select,
// counts retired instructions, and hands the memories to the external
// program loader while the core is parked in IDLE or HALT.
//
// Build option: define SEQ_SINGLE_STEP_EN to add the `step` input. A step
// pulse in IDLE (with no loader request) runs exactly one instruction and
// then returns to IDLE whatever the level of `run`.

module cpu_stage_sequencer #(
    parameter logic [5:0] HALT_OPCODE = 6'b111111,
    parameter int         CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load_req,
    input  logic [5:0]       opcode,
    input  logic             branch_taken,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             load_gnt,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             rf_we,
    output logic             dmem_we,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [1:0] PC_NEXT   = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Set when the current instruction was launched by a step pulse.
    logic             step_mode_q, step_mode_d;
    logic             step_w;

`ifdef SEQ_SINGLE_STEP_EN
    assign step_w = step;
`else
    assign step_w = 1'b0;
`endif

    // Opcode classes. HALT is resolved in DECODE and never reaches EXEC/WB,
    // so the remaining classes need no exclusion of HALT_OPCODE.
    logic is_halt, is_rtype, is_imm, is_lw, is_sw, is_seti, is_br, is_jal, is_jmp;

    assign is_halt  = (opcode == HALT_OPCODE);
    assign is_rtype = (opcode == 6'd0);
    assign is_imm   = (opcode inside {[6'd1:6'd5]});
    assign is_lw    = (opcode == 6'd7);
    assign is_sw    = (opcode == 6'd8);
    assign is_seti  = (opcode inside {[6'd9:6'd11]});
    assign is_br    = (opcode inside {[6'd16:6'd23]});
    assign is_jal   = (opcode == 6'd26);
    assign is_jmp   = (opcode inside {[6'd24:6'd62]}) && !is_jal;

    assign instr_count = cnt_q;

    // State, step-mode flag and retired-instruction counter registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples the pre-edge values; blocking here would create ordering races.
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            step_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_mode_q <= step_mode_d;
        end
    end

    // Next-state decode plus all stage strobes and write enables.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case statement leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_mode_d = step_mode_q;
        load_gnt    = 1'b0;
        fetch_en    = 1'b0;
        decode_en   = 1'b0;
        exec_en     = 1'b0;
        mem_en      = 1'b0;
        wb_en       = 1'b0;
        rf_we       = 1'b0;
        dmem_we     = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = PC_NEXT;
        busy        = 1'b0;
        halted      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Loader wins over run/step; the grant is held off while
                // reset is asserted so all outputs read zero during reset.
                load_gnt = load_req && !rst;
                if (!load_req) begin
                    if (step_w) begin
                        state_d     = S_FETCH;
                        step_mode_d = 1'b1;
                    end else if (run) begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                busy     = 1'b1;
                fetch_en = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                busy      = 1'b1;
                decode_en = 1'b1;
                state_d   = is_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                busy    = 1'b1;
                exec_en = 1'b1;
                state_d = (is_lw || is_sw) ? S_MEM : S_WB;
            end
            S_MEM: begin
                busy    = 1'b1;
                mem_en  = 1'b1;
                dmem_we = is_sw;
                state_d = S_WB;
            end
            S_WB: begin
                busy   = 1'b1;
                wb_en  = 1'b1;
                pc_en  = 1'b1;
                rf_we  = is_rtype || is_imm || is_lw || is_seti || is_jal;
                if (is_jmp || is_jal) begin
                    pc_sel = PC_JUMP;
                end else if (is_br && branch_taken) begin
                    pc_sel = PC_BRANCH;
                end
                cnt_d       = cnt_q + CNT_W'(1);
                step_mode_d = 1'b0;
                // A stepped instruction always parks in IDLE afterwards.
                state_d     = (run && !step_mode_q) ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                halted   = 1'b1;
                load_gnt = load_req && !rst;
                if (!run && !load_req) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Self-checking bench for cpu_stage_sequencer. Expected per-cycle output
// snapshots are queued when an instruction is launched and popped/compared
// on each falling edge. A narrow counter width makes the wrap reachable.

module tb_cpu_stage_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             load_req;
    logic [5:0]       opcode;
    logic             branch_taken;
`ifdef SEQ_SINGLE_STEP_EN
    logic             step;
`endif
    logic             load_gnt;
    logic             fetch_en, decode_en, exec_en, mem_en, wb_en;
    logic             rf_we, dmem_we, pc_en;
    logic [1:0]       pc_sel;
    logic             busy, halted;
    logic [CNT_W-1:0] instr_count;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic             f, d, e, m, w;
        logic             rf, dw, pe;
        logic [1:0]       sel;
        logic             busy, halted, gnt;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    obs_t             exp_q[$];
    logic [CNT_W-1:0] cnt_exp;

    always #5 clk = ~clk;

    cpu_stage_sequencer #(
        .HALT_OPCODE (6'b111111),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .load_req     (load_req),
        .opcode       (opcode),
        .branch_taken (branch_taken),
`ifdef SEQ_SINGLE_STEP_EN
        .step         (step),
`endif
        .load_gnt     (load_gnt),
        .fetch_en     (fetch_en),
        .decode_en    (decode_en),
        .exec_en      (exec_en),
        .mem_en       (mem_en),
        .wb_en        (wb_en),
        .rf_we        (rf_we),
        .dmem_we      (dmem_we),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .busy         (busy),
        .halted       (halted),
        .instr_count  (instr_count)
    );

    function automatic obs_t observe();
        obs_t o;
        o.f = fetch_en;  o.d = decode_en; o.e = exec_en; o.m = mem_en; o.w = wb_en;
        o.rf = rf_we;    o.dw = dmem_we;  o.pe = pc_en;  o.sel = pc_sel;
        o.busy = busy;   o.halted = halted; o.gnt = load_gnt;
        o.cnt = instr_count;
        return o;
    endfunction

    // Launch one instruction whose FETCH begins on the next rising edge.
    // run is changed to run_after during DECODE; idle_after expects IDLE
    // in the cycle following WB.
    task automatic do_instr(input logic [5:0] op, input logic br, input logic rf,
                            input logic [1:0] sel, input logic is_mem, input logic is_sw,
                            input logic run_after, input logic idle_after);
        obs_t e, o;
        int   n;
        opcode       = op;
        branch_taken = br;
        e = '0; e.busy = 1'b1; e.cnt = cnt_exp;
        e.f = 1'b1; exp_q.push_back(e); e.f = 1'b0;
        e.d = 1'b1; exp_q.push_back(e); e.d = 1'b0;
        e.e = 1'b1; exp_q.push_back(e); e.e = 1'b0;
        if (is_mem) begin
            e.m = 1'b1; e.dw = is_sw; exp_q.push_back(e); e.m = 1'b0; e.dw = 1'b0;
        end
        e.w = 1'b1; e.pe = 1'b1; e.rf = rf; e.sel = sel; exp_q.push_back(e);
        cnt_exp = cnt_exp + CNT_W'(1);
        if (idle_after) begin
            e = '0; e.cnt = cnt_exp; exp_q.push_back(e);
        end
        n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL instr op=%0d cycle=%0d got=%h exp=%h", op, n, o, e);
            end
`ifdef SEQ_SINGLE_STEP_EN
            if (n == 0) step = 1'b0;
`endif
            if (n == 1) run = run_after;
            n++;
        end
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1; run = 1'b1; load_req = 1'b0; opcode = 6'd0; branch_taken = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        cnt_exp = '0;
        @(negedge clk);
        o = observe();
        checks++;
        if (o !== obs_t'(0)) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", o, obs_t'(0));
        end
        rst = 1'b0; run = 1'b0;
        @(negedge clk);
        o = observe();
        checks++;
        if (o !== obs_t'(0)) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", o, obs_t'(0));
        end
    endtask

    // R-type, then SW and LW back to back; run drops during the LW.
    task automatic test_rtype_mem();
        run = 1'b1;
        do_instr(6'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(6'd8, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        do_instr(6'd7, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run = 1'b1;
        do_instr(6'd16, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(6'd23, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(6'd26, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(6'd24, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(6'd62, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(6'd3,  1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(6'd10, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_instr(6'd6,  1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_load_arb();
        obs_t e, o;
        int   n;
        load_req = 1'b1; run = 1'b1;
        e = '0; e.gnt = 1'b1; e.cnt = cnt_exp;
        for (int i = 0; i < 3; i++) exp_q.push_back(e);
        n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL load_arb cycle=%0d got=%h exp=%h", n, o, e);
            end
            n++;
        end
        load_req = 1'b0;
        do_instr(6'd1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_halt();
        obs_t e, o;
        int   n;
        opcode = 6'd63; branch_taken = 1'b1; run = 1'b1;
        e = '0; e.busy = 1'b1; e.cnt = cnt_exp;
        e.f = 1'b1; exp_q.push_back(e); e.f = 1'b0;
        e.d = 1'b1; exp_q.push_back(e);
        e = '0; e.halted = 1'b1; e.cnt = cnt_exp;
        exp_q.push_back(e);
        exp_q.push_back(e);
        e.gnt = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(e);
        e = '0; e.cnt = cnt_exp;
        exp_q.push_back(e);
        n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL halt cycle=%0d got=%h exp=%h", n, o, e);
            end
            case (n)
                3: load_req = 1'b1;
                4: run = 1'b0;
                5: load_req = 1'b0;
                default: ;
            endcase
            n++;
        end
    endtask

    // Enough back-to-back NOPs to carry the narrow counter through zero.
    task automatic test_wrap();
        run = 1'b1;
        for (int i = 0; i < 17; i++) begin
            do_instr((i % 2 == 0) ? 6'd12 : 6'd14, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0,
                     (i != 16), (i == 16));
        end
    endtask

    task automatic test_reset_mid();
        obs_t e, o;
        int   n;
        opcode = 6'd0; branch_taken = 1'b0; run = 1'b1;
        e = '0; e.busy = 1'b1; e.cnt = cnt_exp;
        e.f = 1'b1; exp_q.push_back(e); e.f = 1'b0;
        e.d = 1'b1; exp_q.push_back(e); e.d = 1'b0;
        e.e = 1'b1; exp_q.push_back(e);
        cnt_exp = '0;
        exp_q.push_back(obs_t'(0));
        exp_q.push_back(obs_t'(0));
        n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = observe();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid cycle=%0d got=%h exp=%h", n, o, e);
            end
            if (n == 2) rst = 1'b1;
            if (n == 3) begin
                rst = 1'b0;
                run = 1'b0;
            end
            n++;
        end
    endtask

`ifdef SEQ_SINGLE_STEP_EN
    // run rises mid-instruction, yet the stepped instruction still parks in IDLE.
    task automatic test_single_step();
        run  = 1'b0;
        step = 1'b1;
        do_instr(6'd9, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        run = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rtype_mem();
        test_back_to_back();
        test_load_arb();
        test_halt();
        test_wrap();
        test_reset_mid();
`ifdef SEQ_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
